sync_fwft_fifo: RTL and testbench
=================================

Name: sync_fwft_fifo

Overview:
Single-clock FIFO built on a dual-port block-RAM array with a registered synchronous read. It presents first-word-fall-through (FWFT) output: the head word is already on data_out while rd_valid is high, and a read pops it. Occupancy count, almost-full and almost-empty thresholds, and sticky overflow/underflow flags are added for MAC-side rate matching within one clock domain.

Parameters:
WIDTH, 8, data word width in bits
SIZE, 4, address width; RAM depth DEPTH = 2**SIZE; SIZE >= 1
AFULL_THRESH, 2**SIZE-2, almost_full asserts when RAM occupancy >= this value
AEMPTY_THRESH, 2, almost_empty asserts when total count <= this value

Ports:
clk  input  1  single clock; all logic is on its rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  write request
data_in  input  WIDTH  write data
full  output  1  RAM holds DEPTH words; writes are rejected
almost_full  output  1  RAM occupancy >= AFULL_THRESH
rd_en  input  1  pop the head word; honoured only when rd_valid=1
data_out  output  WIDTH  head word, valid while rd_valid=1
rd_valid  output  1  data_out holds a valid word
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  SIZE+1  total words held = RAM occupancy + rd_valid
overflow  output  1  sticky; set by wr_en while full
underflow  output  1  sticky; set by rd_en while !rd_valid

Behaviour:
- Reset (rst=1 at an edge): wr_ptr, rd_ptr (SIZE+1 bits each, extra MSB for wrap) = 0; rd_valid=0; data_out=0; overflow=underflow=0. Outputs then read full=0, almost_full=0 (AFULL_THRESH>0), almost_empty=1, count=0.
- Reset mid-operation discards all held words. RAM contents are not cleared, and stale words are never presented.
- RAM occupancy ram_cnt = wr_ptr - rd_ptr, modulo 2**(SIZE+1). full = (ram_cnt == DEPTH). Empty RAM means ram_cnt == 0.
- Write: accepted when wr_en && !full. data_in goes to RAM[wr_ptr[SIZE-1:0]], then wr_ptr+1. wr_en && full: word dropped, pointers unchanged, overflow<=1.
- Prefetch: when (!rd_valid || rd_en) && ram_cnt != 0, read RAM[rd_ptr[SIZE-1:0]] into data_out, rd_ptr+1, rd_valid<=1. The RAM read register is data_out itself.
- Pop without refill: rd_en && rd_valid && ram_cnt == 0 -> rd_valid<=0; data_out holds its last value.
- rd_en && !rd_valid: no state change except underflow<=1.
- No same-cycle write-to-read bypass. Prefetch sees only words written on earlier edges.
- Latency: a write at edge N into an empty FIFO gives rd_valid=1 with that word after edge N+1 (visible in cycle N+2).
- Throughput: one word per cycle sustained with continuous rd_en, with no bubbles once rd_valid is high and RAM is non-empty.
- Total capacity: DEPTH+1 words (DEPTH in RAM plus one in the output register).
- full is evaluated on the pre-edge state. A pop/prefetch in the same cycle does not admit a write while full.
- Simultaneous accepted write and prefetch: both pointers advance, ram_cnt unchanged.
- Pointer wrap: the low SIZE bits index RAM; the MSB distinguishes full from empty. Wrap is seamless.
- Flags and count are derived combinationally from registered pointers and rd_valid, so they update on the same edge as the state.
- overflow and underflow clear only on rst.

Test Plan:
1. Assert rst 2 cycles -> count=0, rd_valid=0, data_out=0, full=0, almost_empty=1, overflow=underflow=0.
2. Single write 0xA5 at edge 0, no reads -> rd_valid=1, data_out=0xA5, count=1 after edge 1. rd_en 1 cycle -> rd_valid=0, count=0.
3. SIZE=4: write 0x00..0x10 (17 words) with no reads -> all accepted, full=1, count=17, data_out=0x00. An 18th write (0x11) -> overflow=1, count stays 17. Drain returns 0x00..0x10 in order.
4. Stream 100 words (value = index) with wr_en every cycle and rd_en=rd_valid -> first rd_valid 2 cycles after first write, then one word per cycle. Output sequence equals input, including across pointer wrap.
5. Empty FIFO, pulse rd_en -> underflow=1, count=0, rd_valid=0. A later write 0x3C is still delivered normally; underflow stays 1.
6. Hold 5 words, assert rst for 1 cycle while wr_en=1 -> count=0, rd_valid=0 after the edge, and the write during reset is discarded. Then write 0x77 -> data_out=0x77, not stale data.

Source files
------------

// File: rtl/sync_fwft_fifo_if.sv
// Handshake bundle for sync_fwft_fifo: write side, FWFT read side, level and error flags.
interface sync_fwft_fifo_if #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 4
);
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             almost_full;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             almost_empty;
    logic [SIZE:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, data_in, rd_en,
        input  full, almost_full, data_out, rd_valid, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output full, almost_full, data_out, rd_valid, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fwft_fifo.sv
// Single-clock FWFT FIFO: block-RAM storage whose registered read port doubles as the
// output register, giving DEPTH+1 words of capacity with level and sticky error flags.
module sync_fwft_fifo #(
    parameter int WIDTH         = 8,
    parameter int SIZE          = 4,
    parameter int AFULL_THRESH  = 2**SIZE - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    sync_fwft_fifo_if.slave   bus
);
    localparam int            DEPTH    = 2**SIZE;
    localparam logic [SIZE:0] DEPTH_L  = (SIZE+1)'(DEPTH);
    localparam logic [SIZE:0] AFULL_L  = (SIZE+1)'(AFULL_THRESH);
    localparam logic [SIZE:0] AEMPTY_L = (SIZE+1)'(AEMPTY_THRESH);
    localparam logic [SIZE:0] PTR_ONE  = (SIZE+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SIZE:0]    wr_ptr;
    logic [SIZE:0]    rd_ptr;
    logic [SIZE:0]    ram_cnt;
    logic [SIZE:0]    count;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             wr_ok;
    logic             prefetch;

    // Pointers carry one extra MSB so that equal low bits can mean either empty or full.
    assign ram_cnt  = wr_ptr - rd_ptr;
    assign full     = (ram_cnt == DEPTH_L);
    assign wr_ok    = bus.wr_en && !full;
    assign prefetch = (!rd_valid || bus.rd_en) && (ram_cnt != '0);
    assign count    = ram_cnt + (SIZE+1)'(rd_valid);

    // NOTE: the RAM array has no reset; pointers and rd_valid alone decide what is presented,
    // so stale contents are unreachable and the array still maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst)
            mem[wr_ptr[SIZE-1:0]] <= bus.data_in;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, which is what makes full/prefetch evaluate on the old state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (bus.wr_en && full)
                overflow <= 1'b1;
            if (bus.rd_en && !rd_valid)
                underflow <= 1'b1;
            if (prefetch) begin
                data_out <= mem[rd_ptr[SIZE-1:0]];
                rd_ptr   <= rd_ptr + PTR_ONE;
                rd_valid <= 1'b1;
            end else if (bus.rd_en) begin
                rd_valid <= 1'b0;
            end
        end
    end

    assign bus.full         = full;
    assign bus.almost_full  = (ram_cnt >= AFULL_L);
    assign bus.almost_empty = (count <= AEMPTY_L);
    assign bus.count        = count;
    assign bus.data_out     = data_out;
    assign bus.rd_valid     = rd_valid;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: tb/tb_sync_fwft_fifo.sv
// Self-checking bench for sync_fwft_fifo: directed scenarios plus randomized traffic,
// scored against a queue-based behavioural model of the FIFO.
module tb_sync_fwft_fifo;
    localparam int WIDTH  = 8;
    localparam int SIZE   = 4;
    localparam int DEPTH  = 2**SIZE;
    localparam int AFULL  = DEPTH - 2;
    localparam int AEMPTY = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sync_fwft_fifo_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

    sync_fwft_fifo #(
        .WIDTH(WIDTH), .SIZE(SIZE), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: words still in RAM as a queue, plus the one-word output stage.
    logic [WIDTH-1:0] ram_q [$];
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    bit               m_ovf;
    bit               m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        return ram_q.size() + (m_valid ? 1 : 0);
    endfunction

    task automatic model_edge();
        bit full_pre, pf;
        if (rst) begin
            ram_q.delete();
            m_valid = 0;
            m_data  = '0;
            m_ovf   = 0;
            m_unf   = 0;
        end else begin
            full_pre = (ram_q.size() == DEPTH);
            pf       = (!m_valid || bus.rd_en) && (ram_q.size() != 0);
            if (bus.rd_en && !m_valid) m_unf = 1;
            if (pf) begin
                m_data  = ram_q.pop_front();
                m_valid = 1;
            end else if (bus.rd_en) begin
                m_valid = 0;
            end
            // Write lands after the prefetch decision: no same-cycle bypass.
            if (bus.wr_en) begin
                if (full_pre) m_ovf = 1;
                else          ram_q.push_back(bus.data_in);
            end
        end
    endtask

    task automatic compare_all();
        check("count",        32'(bus.count),        32'(m_count()));
        check("rd_valid",     32'(bus.rd_valid),     32'(m_valid));
        check("data_out",     32'(bus.data_out),     32'(m_data));
        check("full",         32'(bus.full),         32'(ram_q.size() == DEPTH));
        check("almost_full",  32'(bus.almost_full),  32'(ram_q.size() >= AFULL));
        check("almost_empty", 32'(bus.almost_empty), 32'(m_count() <= AEMPTY));
        check("overflow",     32'(bus.overflow),     32'(m_ovf));
        check("underflow",    32'(bus.underflow),    32'(m_unf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit w, input logic [WIDTH-1:0] d, input bit r);
        bus.wr_en   = w;
        bus.data_in = d;
        bus.rd_en   = r;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        drive(0, '0, 0);
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4*DEPTH && (ram_q.size() != 0 || m_valid); i++) begin
            drive(0, '0, m_valid);
            tick();
        end
        drive(0, '0, 0);
        check("drained_count", 32'(bus.count), 32'd0);
    endtask

    initial begin
        int wp, rp;
        rst = 1'b1;
        drive(0, '0, 0);

        // Reset state
        do_reset(2);
        check("rst_count",   32'(bus.count),        32'd0);
        check("rst_valid",   32'(bus.rd_valid),     32'd0);
        check("rst_data",    32'(bus.data_out),     32'd0);
        check("rst_full",    32'(bus.full),         32'd0);
        check("rst_aempty",  32'(bus.almost_empty), 32'd1);
        check("rst_ovf",     32'(bus.overflow),     32'd0);
        check("rst_unf",     32'(bus.underflow),    32'd0);

        // Single word: visible one edge after the write edge
        drive(1, 8'hA5, 0);
        tick();
        check("single_not_yet", 32'(bus.rd_valid), 32'd0);
        drive(0, '0, 0);
        tick();
        check("single_valid", 32'(bus.rd_valid), 32'd1);
        check("single_data",  32'(bus.data_out), 32'hA5);
        check("single_count", 32'(bus.count),    32'd1);
        drive(0, '0, 1);
        tick();
        drive(0, '0, 0);
        check("single_pop_valid", 32'(bus.rd_valid), 32'd0);
        check("single_pop_count", 32'(bus.count),    32'd0);

        // Fill to DEPTH+1, then one rejected write
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1, 8'(i), 0);
            tick();
        end
        check("fill_full",  32'(bus.full),     32'd1);
        check("fill_count", 32'(bus.count),    32'(DEPTH + 1));
        check("fill_head",  32'(bus.data_out), 32'h00);
        drive(1, 8'h11, 0);
        tick();
        check("fill_ovf",   32'(bus.overflow), 32'd1);
        check("fill_count_hold", 32'(bus.count), 32'(DEPTH + 1));
        drain();

        // Streaming 100 words across pointer wrap
        do_reset(1);
        drive(1, 8'd0, 0);
        tick();
        check("stream_lat0", 32'(bus.rd_valid), 32'd0);
        drive(1, 8'd1, m_valid);
        tick();
        check("stream_lat1", 32'(bus.rd_valid), 32'd1);
        check("stream_first", 32'(bus.data_out), 32'd0);
        for (int i = 2; i < 100; i++) begin
            drive(1, 8'(i), m_valid);
            tick();
            check("stream_order", 32'(bus.data_out), 32'(i - 1));
        end
        drain();
        check("stream_no_ovf", 32'(bus.overflow), 32'd0);

        // Underflow on empty, later write still delivered
        drive(0, '0, 1);
        tick();
        check("unf_set",   32'(bus.underflow), 32'd1);
        check("unf_count", 32'(bus.count),     32'd0);
        drive(1, 8'h3C, 0);
        tick();
        drive(0, '0, 0);
        tick();
        check("unf_data",   32'(bus.data_out),  32'h3C);
        check("unf_sticky", 32'(bus.underflow), 32'd1);
        drain();

        // Reset mid-operation with a write pending
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(8'h50 + i), 0);
            tick();
        end
        rst = 1'b1;
        drive(1, 8'h99, 0);
        tick();
        rst = 1'b0;
        drive(0, '0, 0);
        check("mid_rst_count", 32'(bus.count),    32'd0);
        check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        tick();
        check("mid_rst_discard", 32'(bus.count), 32'd0);
        drive(1, 8'h77, 0);
        tick();
        drive(0, '0, 0);
        tick();
        check("mid_rst_fresh", 32'(bus.data_out), 32'h77);
        drain();

        // Randomized traffic with varying fill/drain bias and rare resets
        for (int blk = 0; blk < 10; blk++) begin
            wp = $urandom_range(10, 95);
            rp = $urandom_range(10, 95);
            for (int c = 0; c < 200; c++) begin
                rst = ($urandom_range(0, 399) == 0);
                drive($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp);
                tick();
            end
        end
        rst = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
